// File: rtl/spart_tx_if.sv
// SPART transmit bus interface.
// Groups the bus-driver cycle signals and the tbr flow-control return.
//   iocs    : chip select from driver
//   iorw    : 1 = read, 0 = write
//   ioaddr  : 00 TX data, 01 status, 10 divisor low, 11 divisor high
//   databus : write data from driver
//   tbr     : 1 = transmit buffer empty, a TX write is accepted
interface spart_tx_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, databus, input tbr);
    modport slave  (input iocs, iorw, ioaddr, databus, output tbr);
endinterface

// File: rtl/spart_tx.sv
// SPART transmitter: decodes driver bus cycles, holds a 16-bit baud
// divisor, generates the oversample tick and serialises 8N1 frames.
//   clk       : system clock
//   rst       : synchronous, active-high reset
//   bus       : driver bus (slave side), tbr returned as flow control
//   txd       : serial output, idle high, registered
//   baud_tick : one-cycle oversample strobe for the receiver
module spart_tx #(
    parameter logic [15:0] DIV_RESET  = 16'd325,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    spart_tx_if.slave  bus,
    output logic       txd,
    output logic       baud_tick
);

    localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    tbuf_q, tbuf_d;
    logic          full_q, full_d;
    logic          txd_q, txd_d;

    logic          div_wr, tx_wr, tick, bit_end, load;
    logic [15:0]   div_eff;

    assign tick      = (cnt_q <= 16'd1);
    assign baud_tick = tick;
    assign bit_end   = tick && (tcnt_q == TW'(OVERSAMPLE - 1));
    assign bus.tbr   = ~full_q;
    assign txd       = txd_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tbuf_d  = tbuf_q;
        full_d  = full_q;
        load    = 1'b0;

        // Divisor bytes load regardless of iorw.
        div_wr = bus.iocs && bus.ioaddr[1];
        if (div_wr) begin
            if (bus.ioaddr[0]) div_d[15:8] = bus.databus;
            else               div_d[7:0]  = bus.databus;
        end
        div_eff = (div_d == 16'd0) ? 16'd1 : div_d;

        tx_wr = bus.iocs && !bus.iorw && (bus.ioaddr == 2'b00) && !full_q;

        if (state_q != IDLE && tick)
            tcnt_d = bit_end ? '0 : tcnt_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame when a byte is waiting.
                    if (full_q) begin
                        load    = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d = tbuf_q;
            full_d  = 1'b0;
            tcnt_d  = '0;
        end
        // Cannot coincide with load: a write needs an empty buffer.
        if (tx_wr) begin
            tbuf_d = bus.databus;
            full_d = 1'b1;
        end

        // Reload on tick, on any divisor write, and on leaving IDLE so the
        // start bit begins with a full divisor period.
        if (tick || div_wr || (load && state_q == IDLE)) cnt_d = div_eff;
        else                                             cnt_d = cnt_q - 16'd1;

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[idx_d];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= DIV_RESET;
            cnt_q   <= DIV_RESET;
            tcnt_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tbuf_q  <= '0;
            full_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tbuf_q  <= tbuf_d;
            full_q  <= full_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: tb/tb_spart_tx.sv
module tb_spart_tx;
    logic clk = 1'b0;
    logic rst;
    logic txd;
    logic baud_tick;

    spart_tx_if bif();

    spart_tx #(.DIV_RESET(16'd325), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .txd       (txd),
        .baud_tick (baud_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: each accepted byte becomes a frame with a known
    // write cycle, start cycle and bit length; txd/tbr follow from these.
    typedef struct {
        int         w;
        int         s;
        int         len;
        logic [7:0] d;
    } frame_t;
    frame_t      fq[$];
    logic [15:0] mdiv;
    bit          rst_pend;

    int   txd_bad, tbr_bad, txd_fc, tbr_fc;
    logic txd_fa, txd_fe, tbr_fa, tbr_fe;

    function automatic int eff_div();
        return (mdiv == 16'd0) ? 1 : int'(mdiv);
    endfunction

    function automatic int last_end();
        if (fq.size() == 0) return 0;
        return fq[fq.size()-1].s + 10 * fq[fq.size()-1].len;
    endfunction

    function automatic logic exp_txd(input int c);
        int b;
        logic [7:0] d;
        foreach (fq[i]) begin
            if (c >= fq[i].s && c < fq[i].s + 10 * fq[i].len) begin
                b = (c - fq[i].s) / fq[i].len;
                d = fq[i].d;
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return d[b-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_tbr(input int c);
        foreach (fq[i])
            if (fq[i].w < c && c < fq[i].s) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clr_bad();
        txd_bad = 0;
        tbr_bad = 0;
    endtask

    // Advance one cycle and tally waveform disagreements with the model.
    task automatic step();
        logic e;
        @(negedge clk);
        cyc++;
        if (rst_pend) begin
            fq.delete();
            mdiv     = 16'd325;
            rst_pend = 1'b0;
        end
        e = exp_txd(cyc);
        if (txd !== e) begin
            if (txd_bad == 0) begin txd_fc = cyc; txd_fa = txd; txd_fe = e; end
            txd_bad++;
        end
        e = exp_tbr(cyc);
        if (bif.tbr !== e) begin
            if (tbr_bad == 0) begin tbr_fc = cyc; tbr_fa = bif.tbr; tbr_fe = e; end
            tbr_bad++;
        end
    endtask

    task automatic run_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d, input logic rw);
        frame_t f;
        bif.iocs    = 1'b1;
        bif.iorw    = rw;
        bif.ioaddr  = a;
        bif.databus = d;
        if (a[1]) begin
            if (a[0]) mdiv[15:8] = d;
            else      mdiv[7:0]  = d;
        end else if (a == 2'b00 && !rw && exp_tbr(cyc)) begin
            f.w   = cyc;
            f.s   = (cyc + 2 > last_end()) ? cyc + 2 : last_end();
            f.len = 16 * eff_div();
            f.d   = d;
            fq.push_back(f);
        end
        step();
        bif.iocs = 1'b0;
        bif.iorw = 1'b1;
    endtask

    task automatic measure_period(output int p);
        int t0;
        int n;
        n = 0;
        while (baud_tick !== 1'b1 && n < 2000) begin step(); n++; end
        t0 = cyc;
        step();
        n = 0;
        while (baud_tick !== 1'b1 && n < 2000) begin step(); n++; end
        p = (n >= 2000) ? -1 : cyc - t0;
    endtask

    task automatic test_reset();
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++;
        if (bif.tbr !== 1'b1) begin errors++; $display("FAIL reset_tbr: got %b expected 1", bif.tbr); end
        checks++;
        if (baud_tick !== 1'b0) begin errors++; $display("FAIL reset_baud_tick: got %b expected 0", baud_tick); end
    endtask

    task automatic test_baud_default();
        int p;
        measure_period(p);
        checks++;
        if (p !== 325) begin errors++; $display("FAIL default_period: got %0d expected 325", p); end
    endtask

    task automatic test_divisor();
        int p;
        bus_wr(2'b10, 8'h28, 1'b1);
        bus_wr(2'b11, 8'h00, 1'b1);
        repeat (2) begin
            measure_period(p);
            checks++;
            if (p !== 40) begin errors++; $display("FAIL div40_period: got %0d expected 40", p); end
        end
    endtask

    task automatic test_single_frame();
        clr_bad();
        bus_wr(2'b00, 8'h55, 1'b0);
        checks++;
        if (bif.tbr !== 1'b0) begin errors++; $display("FAIL lat_tbr_k1: got %b expected 0", bif.tbr); end
        step();
        checks++;
        if (bif.tbr !== 1'b1 || txd !== 1'b0)
            begin errors++; $display("FAIL lat_k2: got tbr=%b txd=%b expected tbr=1 txd=0", bif.tbr, txd); end
        run_until(last_end() + 4);
        checks++;
        if (txd_bad !== 0) begin errors++;
            $display("FAIL frame55_txd: %0d bad cycles, first cyc %0d got %b expected %b", txd_bad, txd_fc, txd_fa, txd_fe); end
        checks++;
        if (tbr_bad !== 0) begin errors++;
            $display("FAIL frame55_tbr: %0d bad cycles, first cyc %0d got %b expected %b", tbr_bad, tbr_fc, tbr_fa, tbr_fe); end
    endtask

    task automatic test_back_to_back();
        int e1;
        int n;
        clr_bad();
        bus_wr(2'b00, 8'hA3, 1'b0);
        e1 = last_end();
        n = 0;
        while (bif.tbr !== 1'b1 && n < 8) begin step(); n++; end
        checks++;
        if (n >= 8) begin errors++; $display("FAIL b2b_tbr_wait: got tbr=%b expected 1 within 8 cycles", bif.tbr); end
        bus_wr(2'b00, 8'h0F, 1'b0);
        run_until(e1 - 1);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL b2b_stop1: got %b expected 1", txd); end
        step();
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL b2b_start2: got %b expected 0", txd); end
        run_until(last_end() + 4);
        checks++;
        if (txd_bad !== 0) begin errors++;
            $display("FAIL b2b_txd: %0d bad cycles, first cyc %0d got %b expected %b", txd_bad, txd_fc, txd_fa, txd_fe); end
        checks++;
        if (tbr_bad !== 0) begin errors++;
            $display("FAIL b2b_tbr: %0d bad cycles, first cyc %0d got %b expected %b", tbr_bad, tbr_fc, tbr_fa, tbr_fe); end
    endtask

    task automatic test_drop_while_busy();
        int n;
        clr_bad();
        bus_wr(2'b00, 8'h3C, 1'b0);
        n = 0;
        while (bif.tbr !== 1'b1 && n < 8) begin step(); n++; end
        bus_wr(2'b00, 8'hC5, 1'b0);
        repeat (50) step();
        checks++;
        if (bif.tbr !== 1'b0) begin errors++; $display("FAIL drop_tbr_busy: got %b expected 0", bif.tbr); end
        bus_wr(2'b00, 8'hFF, 1'b0);
        run_until(last_end() + 4);
        checks++;
        if (txd_bad !== 0) begin errors++;
            $display("FAIL drop_txd: %0d bad cycles, first cyc %0d got %b expected %b", txd_bad, txd_fc, txd_fa, txd_fe); end
        checks++;
        if (tbr_bad !== 0) begin errors++;
            $display("FAIL drop_tbr: %0d bad cycles, first cyc %0d got %b expected %b", tbr_bad, tbr_fc, tbr_fa, tbr_fe); end
    endtask

    task automatic test_reset_mid_frame();
        int p;
        clr_bad();
        bus_wr(2'b00, 8'h00, 1'b0);
        run_until(fq[fq.size()-1].s + 3 * fq[fq.size()-1].len + 7);
        rst      = 1'b1;
        rst_pend = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (txd !== 1'b1 || bif.tbr !== 1'b1)
            begin errors++; $display("FAIL midrst: got txd=%b tbr=%b expected txd=1 tbr=1", txd, bif.tbr); end
        measure_period(p);
        checks++;
        if (p !== 325) begin errors++; $display("FAIL midrst_period: got %0d expected 325", p); end
        checks++;
        if (txd_bad !== 0) begin errors++;
            $display("FAIL midrst_txd: %0d bad cycles, first cyc %0d got %b expected %b", txd_bad, txd_fc, txd_fa, txd_fe); end
    endtask

    task automatic test_div_zero();
        int hi;
        clr_bad();
        bus_wr(2'b10, 8'h00, 1'b1);
        bus_wr(2'b11, 8'h00, 1'b1);
        hi = 0;
        repeat (32) begin step(); if (baud_tick === 1'b1) hi++; end
        checks++;
        if (hi !== 32) begin errors++; $display("FAIL div0_tick: got %0d ticks expected 32", hi); end
        bus_wr(2'b00, 8'($urandom), 1'b0);
        run_until(fq[fq.size()-1].s + 159);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL div0_stop_end: got %b expected 1", txd); end
        run_until(last_end() + 4);
        checks++;
        if (txd_bad !== 0) begin errors++;
            $display("FAIL div0_txd: %0d bad cycles, first cyc %0d got %b expected %b", txd_bad, txd_fc, txd_fa, txd_fe); end
    endtask

    task automatic test_random_frames();
        logic [1:0] a;
        for (int r = 0; r < 4; r++) begin
            clr_bad();
            bus_wr(2'b10, 8'($urandom_range(0, 5)), 1'($urandom));
            bus_wr(2'b11, 8'h00, 1'($urandom));
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    a = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
                    bus_wr(a, 8'($urandom), ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
                end else begin
                    step();
                end
            end
            run_until(last_end() + 4);
            checks++;
            if (txd_bad !== 0) begin errors++;
                $display("FAIL rand%0d_txd: %0d bad cycles, first cyc %0d got %b expected %b", r, txd_bad, txd_fc, txd_fa, txd_fe); end
            checks++;
            if (tbr_bad !== 0) begin errors++;
                $display("FAIL rand%0d_tbr: %0d bad cycles, first cyc %0d got %b expected %b", r, tbr_bad, tbr_fc, tbr_fa, tbr_fe); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bif.iocs    = 1'b0;
        bif.iorw    = 1'b1;
        bif.ioaddr  = 2'b00;
        bif.databus = 8'h00;
        mdiv        = 16'd325;
        rst_pend    = 1'b0;
        clr_bad();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        test_reset();
        test_baud_default();
        test_divisor();
        test_single_frame();
        test_back_to_back();
        test_drop_while_busy();
        test_reset_mid_frame();
        test_div_zero();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
